control_unit: RTL and testbench

Multi-cycle controller that sequences the k_and_s datapath through fetch, decode and execute. It consumes decoded_instruction (type decoded_instruction_type from k_and_s_pkg) and the registered flags. It drives the datapath control strobes and the RAM write enable, and stalls for a configurable number of RAM wait cycles. It sits beside datapath inside the k_and_s top level.

---
 rtl/control_unit.sv | 200 ++++++++++++++++++++
 tb/tb_control_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for the k_and_s datapath.
// Latency: NOP/branches W+2 cycles, ALU/MOVE/STORE W+3, LOAD 2W+3 (W = MEM_WAIT_CYCLES).
// Backpressure: none; RAM latency is absorbed by a fixed wait count in FETCH and LOAD.
//
// Ports:
//   clk, rst_n                    clock and synchronous active-low reset
//   decoded_instruction           instruction currently held in IR
//   zero_op/neg_op/unsigned_overflow/signed_overflow  registered flags
//   branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
//   write_reg_enable, flags_reg_enable, ram_write_enable  datapath strobes
//   halt                          high while halted
//   instr_retired                 pulse on the final cycle of each instruction

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic                    instr_retired
);

  localparam int CW = (MEM_WAIT_CYCLES > 0) ? $clog2(MEM_WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_LOAD   = 3'd2,
    S_STORE  = 3'd3,
    S_ALU    = 3'd4,
    S_MOVE   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wait_done;
  logic            taken;

  assign wait_done = (cnt_q == CNT_LAST);

  // Branch condition, only meaningful while in S_DECODE.
  always_comb begin
    taken = 1'b0;
    case (decoded_instruction)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_op;
      I_BNZERO: taken = !zero_op;
      I_BNEG:   taken = neg_op;
      I_BNNEG:  taken = !neg_op;
      I_BOV:    taken = unsigned_overflow | signed_overflow;
      I_BNOV:   taken = !(unsigned_overflow | signed_overflow);
      default:  taken = 1'b0;
    endcase
  end

  // Next state. The counter defaults to 0, so it clears on every state
  // change and only advances while a wait state is held.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_FETCH: begin
        if (wait_done) state_d = S_DECODE;
        else           cnt_d   = cnt_q + 1'b1;
      end
      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:                     state_d = S_LOAD;
          I_STORE:                    state_d = S_STORE;
          I_ADD, I_SUB, I_AND, I_OR:  state_d = S_ALU;
          I_MOVE:                     state_d = S_MOVE;
          I_HALT:                     state_d = S_HALT;
          default:                    state_d = S_FETCH;
        endcase
      end
      S_LOAD: begin
        if (wait_done) state_d = S_FETCH;
        else           cnt_d   = cnt_q + 1'b1;
      end
      S_STORE, S_ALU, S_MOVE: state_d = S_FETCH;
      S_HALT:                 state_d = S_HALT;
      default:                state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode of the registered state. Gating with rst_n makes every
  // strobe drop in the very cycle reset is applied, so an interrupted LOAD
  // or STORE can never complete a write.
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    instr_retired    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          addr_sel  = 1'b1;
          ir_enable = wait_done;
        end
        S_DECODE: begin
          case (decoded_instruction)
            I_HALT: pc_enable = 1'b0;
            I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR: pc_enable = 1'b1;
            default: begin
              // NOP, unconditional and conditional branches finish here.
              pc_enable     = 1'b1;
              branch        = taken;
              instr_retired = 1'b1;
            end
          endcase
        end
        S_LOAD: begin
          c_sel            = 1'b1;
          write_reg_enable = wait_done;
          instr_retired    = wait_done;
        end
        S_STORE: begin
          ram_write_enable = 1'b1;
          instr_retired    = 1'b1;
        end
        S_ALU: begin
          case (decoded_instruction)
            I_AND:   operation = 2'b01;
            I_OR:    operation = 2'b10;
            I_SUB:   operation = 2'b11;
            default: operation = 2'b00;
          endcase
          write_reg_enable = 1'b1;
          flags_reg_enable = 1'b1;
          instr_retired    = 1'b1;
        end
        S_MOVE: begin
          // MOVE is the source ORed with itself; flags are left untouched.
          operation        = 2'b10;
          write_reg_enable = 1'b1;
          instr_retired    = 1'b1;
        end
        S_HALT:  halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: checks control_unit at MEM_WAIT_CYCLES = 0, 2 and 3 against an
// instruction-level model that expands each instruction into its per-cycle strobes.
// Flags are randomized every cycle unless a directed case pins them.
module tb_control_unit;
  import k_and_s_pkg::*;

  localparam logic [11:0] V_BR   = 12'h800;
  localparam logic [11:0] V_PC   = 12'h400;
  localparam logic [11:0] V_IR   = 12'h200;
  localparam logic [11:0] V_ADDR = 12'h100;
  localparam logic [11:0] V_CSEL = 12'h080;
  localparam logic [11:0] V_WRE  = 12'h010;
  localparam logic [11:0] V_FRE  = 12'h008;
  localparam logic [11:0] V_RWE  = 12'h004;
  localparam logic [11:0] V_HALT = 12'h002;
  localparam logic [11:0] V_RET  = 12'h001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]              rst_n;
  decoded_instruction_type instr;
  logic                    zero_op, neg_op, uov, sov;
  wire  [11:0]             out_vec [3];

  int n_chk  = 0;
  int n_pass = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    control_unit #(.MEM_WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
      .clk                 (clk),
      .rst_n               (rst_n[g]),
      .decoded_instruction (instr),
      .zero_op             (zero_op),
      .neg_op              (neg_op),
      .unsigned_overflow   (uov),
      .signed_overflow     (sov),
      .branch              (out_vec[g][11]),
      .pc_enable           (out_vec[g][10]),
      .ir_enable           (out_vec[g][9]),
      .addr_sel            (out_vec[g][8]),
      .c_sel               (out_vec[g][7]),
      .operation           (out_vec[g][6:5]),
      .write_reg_enable    (out_vec[g][4]),
      .flags_reg_enable    (out_vec[g][3]),
      .ram_write_enable    (out_vec[g][2]),
      .halt                (out_vec[g][1]),
      .instr_retired       (out_vec[g][0])
    );
  end

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %03h expected %03h", tag, got, exp);
  endtask

  function automatic int w_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  // One cycle: sample at the falling edge, then move to just after the next rising edge.
  task automatic step(input int d, input logic [11:0] exp, input string tag);
    @(negedge clk);
    chk($sformatf("%s[w%0d]", tag, w_of(d)), out_vec[d], exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input bit rnd, input logic [3:0] f);
    if (rnd) {zero_op, neg_op, uov, sov} = 4'($urandom);
    else     {zero_op, neg_op, uov, sov} = f;
  endtask

  // Reference: what the decode cycle shows for an instruction and the current flags.
  function automatic logic [11:0] dec_vec(input decoded_instruction_type i);
    bit t;
    case (i)
      I_HALT: return 12'h000;
      I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR: return V_PC;
      default: begin
        case (i)
          I_BRANCH: t = 1;
          I_BZERO:  t = (zero_op == 1);
          I_BNZERO: t = (zero_op == 0);
          I_BNEG:   t = (neg_op == 1);
          I_BNNEG:  t = (neg_op == 0);
          I_BOV:    t = (uov == 1) || (sov == 1);
          I_BNOV:   t = (uov == 0) && (sov == 0);
          default:  t = 0;
        endcase
        return V_PC | V_RET | (t ? V_BR : 12'h000);
      end
    endcase
  endfunction

  function automatic logic [11:0] alu_vec(input decoded_instruction_type i);
    logic [1:0] op;
    case (i)
      I_ADD:   op = 2'b00;
      I_AND:   op = 2'b01;
      I_OR:    op = 2'b10;
      default: op = 2'b11;
    endcase
    return {5'b0, op, 5'b0} | V_WRE | V_FRE | V_RET;
  endfunction

  // Runs one whole instruction on DUT d; the bench plays the IR, loading it
  // on the edge that ends the ir_enable cycle. HALT is followed for 20 cycles.
  task automatic run_instr(input int d, input decoded_instruction_type i,
                           input bit rnd, input logic [3:0] f);
    int w;
    w = w_of(d);
    for (int k = 0; k <= w; k++) begin
      set_flags(rnd, f);
      step(d, V_ADDR | ((k == w) ? V_IR : 12'h000), "fetch");
    end
    instr = i;
    set_flags(rnd, f);
    step(d, dec_vec(i), $sformatf("decode_%s", i.name()));
    case (i)
      I_LOAD:
        for (int k = 0; k <= w; k++)
          step(d, V_CSEL | ((k == w) ? (V_WRE | V_RET) : 12'h000), "load");
      I_STORE: step(d, V_RWE | V_RET, "store");
      I_ADD, I_SUB, I_AND, I_OR: step(d, alu_vec(i), $sformatf("alu_%s", i.name()));
      I_MOVE:  step(d, 12'h040 | V_WRE | V_RET, "move");
      I_HALT:
        for (int k = 0; k < 20; k++) step(d, V_HALT, "halt");
      default: ;
    endcase
  endtask

  task automatic run_random(input int d, input int n);
    logic [3:0] r;
    for (int k = 0; k < n; k++) begin
      do r = 4'($urandom_range(0, 15)); while (r == 4'd15);
      run_instr(d, decoded_instruction_type'(r), 1'b1, 4'h0);
    end
  endtask

  initial begin
    rst_n = 3'b000;
    instr = I_NOP;
    {zero_op, neg_op, uov, sov} = 4'h0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) step(d, 12'h000, "reset");

    // W = 0: directed cases, then random traffic, then halt and recovery.
    rst_n[0] = 1'b1;
    run_instr(0, I_ADD,   1'b1, 4'h0);
    run_instr(0, I_BZERO, 1'b0, 4'b1000);
    run_instr(0, I_BZERO, 1'b0, 4'b0000);
    run_instr(0, I_BOV,   1'b0, 4'b0001);
    run_instr(0, I_BNOV,  1'b0, 4'b0001);
    run_instr(0, I_MOVE,  1'b1, 4'h0);
    run_instr(0, I_STORE, 1'b1, 4'h0);
    run_random(0, 30);
    run_instr(0, I_HALT,  1'b1, 4'h0);
    rst_n[0] = 1'b0;
    step(0, 12'h000, "reset_from_halt");
    rst_n[0] = 1'b1;
    run_instr(0, I_NOP,   1'b1, 4'h0);
    rst_n[0] = 1'b0;

    // W = 2: LOAD timing, then random traffic.
    rst_n[1] = 1'b1;
    run_instr(1, I_LOAD, 1'b1, 4'h0);
    run_random(1, 25);
    rst_n[1] = 1'b0;

    // W = 3: reset in the middle of a LOAD wait, then restart from fetch.
    rst_n[2] = 1'b1;
    instr = I_NOP;
    for (int k = 0; k <= 3; k++) step(2, V_ADDR | ((k == 3) ? V_IR : 12'h000), "fetch");
    instr = I_LOAD;
    step(2, V_PC, "decode_LOAD");
    step(2, V_CSEL, "load_wait");
    step(2, V_CSEL, "load_wait");
    rst_n[2] = 1'b0;
    step(2, 12'h000, "load_reset");
    step(2, 12'h000, "load_reset");
    rst_n[2] = 1'b1;
    run_instr(2, I_NOP, 1'b1, 4'h0);
    run_random(2, 20);
    run_instr(2, I_HALT, 1'b1, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
